dsp_issue_ctrl: RTL

Command sequencer that sits directly upstream of the FB42 DSP datapath and also collects its result. It accepts one multiply/MAC command per valid/ready handshake and expands it into the 1-, 2- or 4-pass operand/`start` sequence the datapath needs. It holds operands stable across the passes, samples the datapath sum after the final-adder latency, and returns the result through a one-entry valid/ready output register.

---
 rtl/dsp_issue_ctrl_pkg.sv | 11 +
 rtl/dsp_issue_ctrl_result_reg.sv | 29 ++
 rtl/dsp_issue_ctrl.sv | 99 +++++++++
 3 files changed

// File: rtl/dsp_issue_ctrl_pkg.sv
// dsp_pkg: shared state encoding, mode constants and pass-count helper for dsp_issue_ctrl
package dsp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [1:0] MODE_HALF    = 2'd0;
  localparam logic [1:0] MODE_MIXED   = 2'd1;
  localparam logic [1:0] MODE_FULL    = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL = 2'd3;
  function automatic logic [2:0] pass_count(input logic [1:0] mode);
    return mode == MODE_MIXED ? 3'd2 : mode == MODE_FULL ? 3'd4 : 3'd1;
  endfunction
endpackage

// File: rtl/dsp_issue_ctrl_result_reg.sv
// dsp_result_reg: one-entry valid/ready holding register for the datapath result and its error flag
module dsp_result_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_err,
  input  logic         res_ready,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic         res_err,
  output logic         free
);
  assign free = !res_valid || res_ready;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else if (load) begin
      res_valid <= 1'b1;
      res_data  <= load_data;
      res_err   <= load_err;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
endmodule

// File: rtl/dsp_issue_ctrl.sv
// dsp_issue_ctrl: expands multiply/MAC commands into FB42 datapath pass sequences and collects the result
module dsp_issue_ctrl
  import dsp_pkg::*;
#(
  parameter int N       = 16,
  parameter int M       = 16,
  parameter int OUT_LAT = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [N-1:0]   cmd_a,
  input  logic [M-1:0]   cmd_b,
  input  logic [N+M-1:0] cmd_c,
  input  logic [1:0]     cmd_mode,
  input  logic           cmd_mac,
  input  logic [1:0]     cmd_shift,
  output logic           dsp_start,
  output logic [1:0]     dsp_mode,
  output logic [N-1:0]   dsp_aa,
  output logic [M-1:0]   dsp_bb,
  output logic [N+M-1:0] dsp_cc,
  output logic           dsp_mac,
  output logic           dsp_mac_start,
  output logic [1:0]     dsp_barrel_shifter,
  input  logic [N+M-1:0] dsp_out,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [N+M-1:0] res_data,
  output logic           res_err
);
  state_t state, state_n;
  logic [1:0] pass_cnt, lat_cnt;
  logic err, mac_prev, free, accept, last_pass, capture;
  assign cmd_ready = reset_n && state == IDLE && free;
  assign accept    = cmd_valid && cmd_ready;
  assign last_pass = {1'b0, pass_cnt} == pass_count(dsp_mode) - 3'd1;
  assign capture   = state == DRAIN && lat_cnt == 2'd0;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (accept ? RUN : IDLE) :
              state == RUN  ? (last_pass ? DRAIN : RUN) :
              (capture ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state              <= IDLE;
      pass_cnt           <= '0;
      lat_cnt            <= '0;
      err                <= 1'b0;
      mac_prev           <= 1'b0;
      dsp_start          <= 1'b0;
      dsp_mode           <= MODE_HALF;
      dsp_aa             <= '0;
      dsp_bb             <= '0;
      dsp_cc             <= '0;
      dsp_mac            <= 1'b0;
      dsp_mac_start      <= 1'b0;
      dsp_barrel_shifter <= '0;
    end else begin
      state         <= state_n;
      dsp_start     <= accept;
      dsp_mac_start <= accept && cmd_mac && !mac_prev;
      if (accept) begin
        pass_cnt           <= '0;
        err                <= cmd_mode == MODE_ILLEGAL;
        mac_prev           <= cmd_mac;
        dsp_mode           <= cmd_mode == MODE_ILLEGAL ? MODE_HALF : cmd_mode;
        dsp_aa             <= cmd_a;
        dsp_bb             <= cmd_b;
        dsp_cc             <= cmd_c;
        dsp_mac            <= cmd_mac;
        dsp_barrel_shifter <= cmd_shift;
      end else if (state == RUN) begin
        pass_cnt <= pass_cnt + 2'd1;
        lat_cnt  <= 2'(OUT_LAT - 1);
        if (last_pass) begin
          dsp_aa   <= '0;
          dsp_bb   <= '0;
          dsp_mode <= MODE_HALF;
        end
      end else if (state == DRAIN) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
    end
  dsp_result_reg #(.W(N + M)) u_result (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (capture),
    .load_data (dsp_out),
    .load_err  (err),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_err   (res_err),
    .free      (free)
  );
endmodule
